// File: rtl/gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_resp_checker
// Purpose  : Settles, samples and checks a 2-input gate DUT response against
//            a truth table; tracks vector coverage, error count and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module gate_resp_checker #(
  parameter logic [3:0] FUNC    = 4'b0001,
  parameter int         SETTLE  = 2,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov
);

  localparam int              c_ST_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int              c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_ST_W-1:0] c_ST_LAST = c_ST_W'(SETTLE - 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
  localparam logic [3:0]      c_COV_ALL = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_SAMPLE   = 3'd2,
    S_WAIT_CHG = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             r_state;
  logic [1:0]         r_prev_ab;
  logic [c_ST_W-1:0]  r_stable_cnt;
  logic [c_TO_W-1:0]  r_to_cnt;

  state_t             w_state_nxt;
  logic [1:0]         w_prev_ab_nxt;
  logic [c_ST_W-1:0]  w_stable_nxt;
  logic [c_TO_W-1:0]  w_to_nxt;
  logic [CNT_W-1:0]   w_err_nxt;
  logic [3:0]         w_cov_nxt;
  logic               w_timeout_nxt;
  logic               w_mismatch_nxt;
  logic [1:0]         w_ab;
  logic               w_changed;
  logic               w_busy_nxt;
  logic               w_pass_nxt;

  assign w_ab      = {a, b};
  assign w_changed = (w_ab != r_prev_ab);

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_ab_nxt  = r_prev_ab;
    w_stable_nxt   = r_stable_cnt;
    w_to_nxt       = r_to_cnt;
    w_err_nxt      = err_cnt;
    w_cov_nxt      = cov;
    w_timeout_nxt  = timeout;
    w_mismatch_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_err_nxt     = '0;
          w_cov_nxt     = 4'b0000;
          w_timeout_nxt = 1'b0;
          w_prev_ab_nxt = w_ab;
          w_stable_nxt  = '0;
          w_state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_changed) begin
          w_prev_ab_nxt = w_ab;
          w_stable_nxt  = '0;
        end else if (r_stable_cnt == c_ST_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_stable_nxt = r_stable_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        // A change landing on the sample cycle means y is not trustworthy yet
        if (w_changed) begin
          w_prev_ab_nxt = w_ab;
          w_stable_nxt  = '0;
          w_state_nxt   = S_SETTLE;
        end else begin
          w_cov_nxt = cov | (4'b0001 << r_prev_ab);
          if (y != FUNC[r_prev_ab]) begin
            w_mismatch_nxt = 1'b1;
            if (!(&err_cnt)) begin
              w_err_nxt = err_cnt + 1'b1;
            end
          end
          if (w_cov_nxt == c_COV_ALL) begin
            w_state_nxt = S_DONE;
          end else begin
            w_to_nxt    = '0;
            w_state_nxt = S_WAIT_CHG;
          end
        end
      end
      S_WAIT_CHG: begin
        if (w_changed) begin
          w_prev_ab_nxt = w_ab;
          w_stable_nxt  = '0;
          w_state_nxt   = S_SETTLE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  assign w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE) ||
                      (w_state_nxt == S_WAIT_CHG);
  assign w_pass_nxt = (w_state_nxt == S_DONE) && (w_cov_nxt == c_COV_ALL) &&
                      (w_err_nxt == '0) && !w_timeout_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev_ab    <= 2'b00;
      r_stable_cnt <= '0;
      r_to_cnt     <= '0;
      err_cnt      <= '0;
      cov          <= 4'b0000;
      timeout      <= 1'b0;
      mismatch     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_ab    <= w_prev_ab_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_to_cnt     <= w_to_nxt;
      err_cnt      <= w_err_nxt;
      cov          <= w_cov_nxt;
      timeout      <= w_timeout_nxt;
      mismatch     <= w_mismatch_nxt;
      busy         <= w_busy_nxt;
      done         <= (w_state_nxt == S_DONE);
      pass         <= w_pass_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_resp_checker
// Purpose  : Directed + random stimulus for gate_resp_checker, checked each
//            cycle against a run-length reference model of a NOR checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_resp_checker;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             y = 1'b1;
  logic             busy, done, pass, timeout, mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       cov;

  always #5 clk = ~clk;

  gate_resp_checker #(
    .FUNC    (4'b0001),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .mismatch (mismatch),
    .err_cnt  (err_cnt),
    .cov      (cov)
  );

  int n_vec = 0;
  int n_err = 0;
  int obs_mis = 0;
  int gate_mode = 0;   // 0 correct NOR, 1 AND, 2 NOR with random faults, 3 always wrong

  // Reference model: tracks how long the current vector has been held
  bit       m_run, m_done, m_pass, m_to, m_mis;
  bit [1:0] m_anchor;
  bit [3:0] m_cov;
  int       m_age, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [1:0] ab;
    ab = {a, b};
    m_mis = 1'b0;
    if (rst) begin
      m_run = 0; m_done = 0; m_to = 0; m_cov = 0; m_err = 0; m_anchor = 0; m_age = 0;
    end else if (!m_run) begin
      if (start) begin
        m_err = 0; m_cov = 0; m_to = 0; m_done = 0;
        m_run = 1; m_anchor = ab; m_age = 0;
      end
    end else if (ab != m_anchor) begin
      m_anchor = ab;
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == SETTLE + 1) begin
        m_cov[ab] = 1'b1;
        if (y !== ~(a | b)) begin
          m_mis = 1'b1;
          if (m_err < ERR_MAX) m_err++;
        end
        if (m_cov == 4'hF) begin
          m_run = 0;
          m_done = 1;
        end
      end else if (m_age == SETTLE + 1 + TIMEOUT) begin
        m_to = 1; m_run = 0; m_done = 1;
      end
    end
    m_pass = m_done && (m_cov == 4'hF) && (m_err == 0) && !m_to;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (mismatch === 1'b1) obs_mis++;
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("pass", pass, m_pass);
    check("timeout", timeout, m_to);
    check("mismatch", mismatch, m_mis);
    check("err_cnt", err_cnt, m_err);
    check("cov", cov, m_cov);
  endtask

  task automatic set_ab(input bit [1:0] ab);
    a = ab[1];
    b = ab[0];
    case (gate_mode)
      0: y = ~(a | b);
      1: y = a & b;
      2: y = ~(a | b) ^ ($urandom_range(0, 3) == 0);
      default: y = a | b;
    endcase
  endtask

  task automatic apply(input bit [1:0] ab, input int hold);
    set_ab(ab);
    repeat (hold) tick();
  endtask

  task automatic pulse_start(input bit [1:0] ab);
    set_ab(ab);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic full_run();
    pulse_start(2'b00);
    apply(2'b00, 10);
    apply(2'b01, 10);
    apply(2'b10, 10);
    apply(2'b11, 10);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_cov", cov, 0);

    // Correct NOR gate
    gate_mode = 0;
    obs_mis = 0;
    full_run();
    check("nor_done", done, 1);
    check("nor_pass", pass, 1);
    check("nor_cov", cov, 4'hF);
    check("nor_mis_pulses", obs_mis, 0);

    // AND gate against NOR table: 00 and 11 disagree
    gate_mode = 1;
    obs_mis = 0;
    full_run();
    check("and_mis_pulses", obs_mis, 2);
    check("and_err", err_cnt, 2);
    check("and_pass", pass, 0);

    // Short glitch on 01, then a change landing exactly on the sample cycle of 11
    gate_mode = 0;
    pulse_start(2'b00);
    apply(2'b00, 10);
    apply(2'b01, 1);
    apply(2'b10, 10);
    check("glitch_cov01", cov[1], 0);
    check("glitch_cov10", cov[2], 1);
    apply(2'b11, SETTLE + 1);
    apply(2'b01, 1);
    check("samp_skip_cov11", cov[3], 0);
    check("samp_skip_busy", busy, 1);
    apply(2'b01, 10);
    apply(2'b11, 10);
    check("glitch_end_pass", pass, 1);

    // Timeout while holding 00
    pulse_start(2'b00);
    apply(2'b00, 20);
    check("to_flag", timeout, 1);
    check("to_cov", cov, 4'b0001);
    check("to_pass", pass, 0);

    // Error counter saturation
    gate_mode = 3;
    pulse_start(2'b00);
    repeat (5) begin
      apply(2'b00, 6);
      apply(2'b01, 6);
    end
    apply(2'b10, 10);
    apply(2'b11, 10);
    check("sat_err", err_cnt, ERR_MAX);

    // Reset in the middle of a run
    gate_mode = 0;
    pulse_start(2'b00);
    apply(2'b00, 10);
    apply(2'b01, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {busy, done, pass, timeout, mismatch, err_cnt, cov}, 0);
    full_run();
    check("midrst_rerun_pass", pass, 1);

    // Random vectors, faulty gate, stray starts and rare resets
    gate_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) start = 1'b1;
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      apply(2'($urandom_range(0, 3)), 1);
      start = 1'b0;
      rst = 1'b0;
      apply({a, b}, $urandom_range(0, 11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Self-checking response monitor for 2-input gate DUTs. Sits on the opposite side of the DUT from the stimulus driver.
- Watches the applied stimulus {a,b} and the DUT output y, waits for the stimulus to settle, then samples y and compares it with a parameterised truth table.
- Counts mismatches, tracks coverage of all four input vectors, and reports done/pass in hardware. This replaces manual inspection of printed values.

Parameters:
- FUNC, 4'b0001, expected truth table; expected y = FUNC[{a,b}]. Default is NOR: only vector 00 gives 1.
- SETTLE, 2, number of consecutive stable cycles before y is sampled; must be at least 1.
- TIMEOUT, 64, maximum cycles to wait for a new stimulus after a sample; must be at least 1.
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a check run.
- a  in  1  stimulus bit a, as applied to the DUT.
- b  in  1  stimulus bit b, as applied to the DUT.
- y  in  1  DUT output.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE, held until the next start or reset.
- pass  out  1  valid when done=1: 1 only if cov=4'b1111, err_cnt=0 and timeout=0.
- timeout  out  1  sticky flag; the run ended because TIMEOUT expired.
- mismatch  out  1  one-cycle pulse in the cycle after a failing sample.
- err_cnt  out  CNT_W  number of mismatches; saturates at all-ones.
- cov  out  4  coverage bitmap; bit {a,b} is set once that vector has been sampled.

Behaviour:
- Reset: synchronous and active-high; one clock; rst has priority over everything.
  - State goes to IDLE.
  - All outputs go to 0: busy, done, pass, timeout, mismatch, err_cnt, cov.
  - Internal prev_ab, stable_cnt and to_cnt go to 0.
  - Reset mid-run aborts the run immediately; no partial result is retained.
- States: IDLE, SETTLE, SAMPLE, WAIT_CHG, DONE.
- IDLE:
  - start=1: clear err_cnt, cov, timeout, done and pass; set prev_ab<={a,b} and stable_cnt<=0; go to SETTLE.
- SETTLE:
  - If {a,b} differs from prev_ab: prev_ab<={a,b}, stable_cnt<=0, stay in SETTLE (this is glitch restart).
  - Else if stable_cnt==SETTLE-1: go to SAMPLE.
  - Else: stable_cnt increments.
- SAMPLE (one cycle):
  - If {a,b} differs from prev_ab: do not check; prev_ab<={a,b}, stable_cnt<=0, go back to SETTLE.
  - Else:
    - Compare y with FUNC[prev_ab] and set cov[prev_ab].
    - On mismatch: err_cnt increments (saturating) and mismatch pulses in the next cycle.
    - If the updated cov is 4'b1111, go to DONE. Otherwise to_cnt<=0 and go to WAIT_CHG.
- WAIT_CHG:
  - If {a,b} differs from prev_ab: prev_ab<={a,b}, stable_cnt<=0, go to SETTLE.
  - Else if to_cnt==TIMEOUT-1: timeout<=1 and go to DONE.
  - Else: to_cnt increments.
- Vector revisits: returning to an already-covered vector is re-checked; err_cnt can grow past 4, and cov is unchanged.
- DONE:
  - done=1, busy=0, pass computed as defined in Ports; outputs are held.
  - start=1 restarts exactly as from IDLE, in the same cycle.
- busy is 1 in SETTLE, SAMPLE and WAIT_CHG, and 0 otherwise.
- start while busy=1 is ignored.
- Latency: a vector held stable from cycle t is sampled at cycle t+SETTLE (SAMPLE state); its check result is visible on err_cnt, cov and mismatch at cycle t+SETTLE+1.
- Outputs are registered; the block has no combinational path from input to output.

Test Plan:
- Correct NOR DUT, SETTLE=2: start, then drive 00, 01, 10, 11, each held 10 cycles -> done=1, pass=1, err_cnt=0, cov=4'b1111, timeout=0, and mismatch never pulses.
- AND DUT with the default FUNC, same sequence -> mismatch pulses exactly twice (vectors 00 and 11), err_cnt=2, cov=4'b1111, done=1, pass=0.
- Glitch: hold 01 for 1 cycle, then switch to 10 and hold 10 cycles, with SETTLE=2 -> no sample of 01 (cov[1]=0) and one sample of 10 (cov[2]=1). Also toggle {a,b} in the SAMPLE cycle -> no check is performed and the FSM returns to SETTLE.
- Timeout, TIMEOUT=8: start, then hold 00 indefinitely -> 00 is sampled once, and 8 cycles later done=1, timeout=1, pass=0, cov=4'b0001.
- Saturation, CNT_W=2, faulty DUT: alternate 00 and 01 every 6 cycles, 5 times, before covering 10 and 11 -> err_cnt stops at 3 and does not wrap.
- Reset mid-run: assert rst for 1 cycle after covering 00 and 01 -> next cycle all outputs are 0 and the state is IDLE; a fresh start followed by a full run gives pass=1.
